// File: rtl/iob_wb_bridge.sv
// IOb manager port to classic single-transfer Wishbone manager, with a bounded
// ack wait so a silent target terminates as an error instead of hanging the bus.
module iob_wb_bridge #(
   parameter int                ADDR_W    = 5,
   parameter int                DATA_W    = 32,
   parameter int                TIMEOUT_W = 4,
   parameter logic [DATA_W-1:0] ERR_DATA  = DATA_W'(32'hDEADBEEF)
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                rst_i,
   input  logic                iob_valid_i,
   input  logic [ADDR_W-1:0]   iob_addr_i,
   input  logic [DATA_W-1:0]   iob_wdata_i,
   input  logic [DATA_W/8-1:0] iob_wstrb_i,
   output logic                iob_ready_o,
   output logic                iob_rvalid_o,
   output logic [DATA_W-1:0]   iob_rdata_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic                wb_we_o,
   output logic [ADDR_W-1:0]   wb_adr_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic                wb_ack_i,
   input  logic                wb_err_i,
   output logic                err_o
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   // Terminal count is checked one early so the counter "reaches" all-ones on
   // the edge that ends the cycle: stb stays high for exactly 2**TIMEOUT_W-1 cycles.
   localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((2**TIMEOUT_W) - 2);

   state_t               state, state_n;
   logic [TIMEOUT_W-1:0] cnt;
   logic                 accept, ack_done, err_done;

   assign iob_ready_o = (state == IDLE);

   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      ack_done = 1'b0;
      err_done = 1'b0;
      case (state)
         IDLE: if (iob_valid_i) begin
            accept  = 1'b1;
            state_n = BUS;
         end
         BUS: begin
            // err beats ack; ack beats the timeout terminal count
            if (wb_err_i) begin
               err_done = 1'b1;
               state_n  = RESP;
            end else if (wb_ack_i) begin
               ack_done = 1'b1;
               state_n  = RESP;
            end else if (cnt == CNT_LAST) begin
               err_done = 1'b1;
               state_n  = RESP;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else if (cke_i) state <= state_n;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt          <= '0;
         iob_rvalid_o <= 1'b0;
         iob_rdata_o  <= '0;
         wb_cyc_o     <= 1'b0;
         wb_stb_o     <= 1'b0;
         wb_we_o      <= 1'b0;
         wb_adr_o     <= '0;
         wb_sel_o     <= '0;
         wb_dat_o     <= '0;
         err_o        <= 1'b0;
      end else if (cke_i) begin
         err_o        <= err_done;
         iob_rvalid_o <= (ack_done | err_done) & ~wb_we_o;
         if (state == BUS) cnt <= cnt + 1'b1;
         if (accept) begin
            cnt      <= '0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= |iob_wstrb_i;
            wb_adr_o <= iob_addr_i;
            wb_dat_o <= iob_wdata_i;
            wb_sel_o <= (|iob_wstrb_i) ? iob_wstrb_i : '1;
         end
         if (ack_done | err_done) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (!wb_we_o) iob_rdata_o <= err_done ? ERR_DATA : wb_dat_i;
         end
      end
   end

endmodule

// File: tb/tb_iob_wb_bridge.sv
// Randomized bench for iob_wb_bridge: each transaction is observed end to end
// and compared with a cycle-count model derived from the bridge's protocol rules.
module tb_iob_wb_bridge;

   logic        clk = 1'b0;
   logic        cke, rst;
   logic        iob_valid;
   logic [4:0]  iob_addr;
   logic [31:0] iob_wdata;
   logic [3:0]  iob_wstrb;
   logic        iob_ready, iob_rvalid;
   logic [31:0] iob_rdata;
   logic        wb_cyc, wb_stb, wb_we;
   logic [4:0]  wb_adr;
   logic [3:0]  wb_sel;
   logic [31:0] wb_dat_o, wb_dat_i;
   logic        wb_ack, wb_err, err_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_rdata;

   typedef struct packed {
      int          stb_first;
      int          stb_cyc;
      int          rv_cnt;
      int          rv_at;
      logic [31:0] rdata;
      int          err_cnt;
      int          ready_at;
      logic        we;
      logic [3:0]  sel;
      logic [4:0]  adr;
      logic [31:0] dat;
   } txn_res_t;

   iob_wb_bridge dut (
      .clk_i(clk), .cke_i(cke), .rst_i(rst),
      .iob_valid_i(iob_valid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
      .iob_wstrb_i(iob_wstrb), .iob_ready_o(iob_ready), .iob_rvalid_o(iob_rvalid),
      .iob_rdata_o(iob_rdata), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
      .wb_adr_o(wb_adr), .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack), .wb_err_i(wb_err), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Target terminates at the first stb cycle carrying err or ack (err first);
   // with neither by cycle 15 the bridge times out. Latencies counted in
   // negedges after the acceptance edge: stb 1..k, RESP k+1, ready k+2.
   function automatic txn_res_t model(input logic [4:0] addr, input logic [31:0] wd,
                                      input logic [3:0] strb, input int ack_at,
                                      input int err_at, input logic [31:0] rd);
      txn_res_t e;
      int  k;
      bit  is_err, rd_op;
      k = 1;
      while (k < 15 && ack_at != k && err_at != k) k++;
      is_err      = (err_at == k) || (ack_at != k);
      rd_op       = (strb == 4'h0);
      e.stb_first = 1;
      e.stb_cyc   = k;
      e.rv_cnt    = rd_op ? 1 : 0;
      e.rv_at     = rd_op ? k + 1 : 0;
      if (rd_op) model_rdata = is_err ? 32'hDEADBEEF : rd;
      e.rdata     = model_rdata;
      e.err_cnt   = is_err ? 1 : 0;
      e.ready_at  = k + 2;
      e.we        = !rd_op;
      e.sel       = rd_op ? 4'hF : strb;
      e.adr       = addr;
      e.dat       = wd;
      return e;
   endfunction

   // Starts on a negedge with the bridge idle; returns on the negedge where ready is back.
   task automatic run_txn(input logic [4:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                          input int ack_at, input int err_at, input logic [31:0] rd,
                          input bit hold_valid, output txn_res_t o);
      o = '0;
      iob_valid = 1'b1; iob_addr = addr; iob_wdata = wd; iob_wstrb = strb;
      @(negedge clk);
      if (!hold_valid) begin
         iob_valid = 1'b0; iob_addr = $urandom; iob_wdata = $urandom; iob_wstrb = $urandom;
      end
      for (int i = 1; i <= 40; i++) begin
         if (wb_stb) begin
            o.stb_cyc++;
            if (o.stb_cyc == 1) begin
               o.stb_first = i; o.we = wb_we; o.sel = wb_sel; o.adr = wb_adr; o.dat = wb_dat_o;
            end
            wb_ack   = (o.stb_cyc == ack_at);
            wb_err   = (o.stb_cyc == err_at);
            wb_dat_i = wb_ack ? rd : $urandom;
         end else begin
            wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = $urandom;
         end
         if (iob_rvalid) begin o.rv_cnt++; o.rv_at = i; end
         if (err_o) o.err_cnt++;
         if (iob_ready) begin
            o.ready_at = i;
            o.rdata    = iob_rdata;
            break;
         end
         @(negedge clk);
      end
      wb_ack = 1'b0; wb_err = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_rdata = '0;
      checks++;
      if (iob_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", iob_ready); end
      checks++;
      if ({wb_cyc, wb_stb, wb_we, iob_rvalid, err_o} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 00000", {wb_cyc, wb_stb, wb_we, iob_rvalid, err_o});
      end
      checks++;
      if ({wb_adr, wb_sel, wb_dat_o, iob_rdata} !== '0) begin
         errors++; $display("FAIL reset_data got adr=%h sel=%h dat=%h rdata=%h exp all 0", wb_adr, wb_sel, wb_dat_o, iob_rdata);
      end
   endtask

   task automatic test_read_zero_wait();
      txn_res_t o, e;
      e = model(5'h04, 32'h0, 4'h0, 1, 0, 32'h12345678);
      run_txn(5'h04, 32'h0, 4'h0, 1, 0, 32'h12345678, 1'b0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL read_zero_wait got %p exp %p", o, e); end
   endtask

   task automatic test_write_wait();
      txn_res_t o, e;
      e = model(5'h08, 32'hA5, 4'h1, 4, 0, 32'h0);
      run_txn(5'h08, 32'hA5, 4'h1, 4, 0, 32'h0, 1'b0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL write_wait got %p exp %p", o, e); end
   endtask

   task automatic test_timeout();
      txn_res_t o, e;
      e = model(5'h10, 32'h0, 4'h0, 0, 0, 32'h0);
      run_txn(5'h10, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL timeout_read got %p exp %p", o, e); end
      // ack landing on the terminal count still completes normally
      e = model(5'h11, 32'h0, 4'h0, 15, 0, 32'h0BADF00D);
      run_txn(5'h11, 32'h0, 4'h0, 15, 0, 32'h0BADF00D, 1'b0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL ack_at_terminal got %p exp %p", o, e); end
      e = model(5'h12, 32'h77, 4'hC, 0, 0, 32'h0);
      run_txn(5'h12, 32'h77, 4'hC, 0, 0, 32'h0, 1'b0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL timeout_write got %p exp %p", o, e); end
   endtask

   task automatic test_wb_err();
      txn_res_t o, e;
      e = model(5'h0C, 32'h0, 4'h0, 0, 2, 32'h0);
      run_txn(5'h0C, 32'h0, 4'h0, 0, 2, 32'h0, 1'b0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL err_read got %p exp %p", o, e); end
      e = model(5'h0D, 32'h0, 4'h0, 3, 3, 32'h11112222);
      run_txn(5'h0D, 32'h0, 4'h0, 3, 3, 32'h11112222, 1'b0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL err_beats_ack got %p exp %p", o, e); end
      checks++;
      if (wb_cyc !== 1'b0) begin errors++; $display("FAIL err_bus_idle got cyc=%b exp 0", wb_cyc); end
   endtask

   task automatic test_back_to_back();
      txn_res_t o1, o2, e1, e2;
      e1 = model(5'h14, 32'hCAFE0001, 4'hF, 2, 0, 32'h0);
      run_txn(5'h14, 32'hCAFE0001, 4'hF, 2, 0, 32'h0, 1'b1, o1);
      e2 = model(5'h18, 32'h0, 4'h0, 1, 0, 32'h5A5A1234);
      run_txn(5'h18, 32'h0, 4'h0, 1, 0, 32'h5A5A1234, 1'b0, o2);
      checks++;
      if (o1 !== e1) begin errors++; $display("FAIL b2b_write got %p exp %p", o1, e1); end
      checks++;
      if (o2 !== e2) begin errors++; $display("FAIL b2b_read got %p exp %p", o2, e2); end
   endtask

   task automatic test_reset_mid_bus();
      txn_res_t o, e;
      iob_valid = 1'b1; iob_addr = 5'h1C; iob_wstrb = 4'h0;
      @(negedge clk);
      iob_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_rdata = '0;
      checks++;
      if ({wb_cyc, wb_stb, iob_rvalid, iob_ready} !== 4'b0001) begin
         errors++; $display("FAIL reset_mid_bus got cyc/stb/rvalid/ready=%b exp 0001", {wb_cyc, wb_stb, iob_rvalid, iob_ready});
      end
      e = model(5'h1D, 32'h0, 4'h0, 2, 0, 32'h600DCAFE);
      run_txn(5'h1D, 32'h0, 4'h0, 2, 0, 32'h600DCAFE, 1'b0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL read_after_reset got %p exp %p", o, e); end
   endtask

   task automatic test_cke_stall();
      iob_valid = 1'b1; iob_addr = 5'h02; iob_wstrb = 4'h0;
      @(negedge clk);
      iob_valid = 1'b0;
      cke = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h1111AAAA;
      repeat (3) @(negedge clk);
      checks++;
      if ({wb_stb, iob_rvalid, iob_ready} !== 3'b100) begin
         errors++; $display("FAIL cke_hold got stb/rvalid/ready=%b exp 100", {wb_stb, iob_rvalid, iob_ready});
      end
      cke = 1'b1; wb_dat_i = 32'h2222BBBB;
      @(negedge clk);
      wb_ack = 1'b0;
      model_rdata = 32'h2222BBBB;
      checks++;
      if ({wb_stb, iob_rvalid, iob_rdata} !== {2'b01, model_rdata}) begin
         errors++; $display("FAIL cke_resume got stb=%b rvalid=%b rdata=%h exp 0 1 %h", wb_stb, iob_rvalid, iob_rdata, model_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      txn_res_t o, e;
      logic [4:0]  a;
      logic [31:0] wd, rd;
      logic [3:0]  s;
      int          ack_at, err_at;
      for (int n = 0; n < 30; n++) begin
         a      = 5'($urandom);
         wd     = $urandom;
         rd     = $urandom;
         s      = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
         ack_at = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(16, 1));
         err_at = ($urandom_range(3) == 0) ? int'($urandom_range(16, 1)) : 0;
         e = model(a, wd, s, ack_at, err_at, rd);
         run_txn(a, wd, s, ack_at, err_at, rd, $urandom_range(1) == 1, o);
         checks++;
         if (o !== e) begin errors++; $display("FAIL random_%0d got %p exp %p", n, o, e); end
      end
      iob_valid = 1'b0;
   endtask

   initial begin
      cke = 1'b1; rst = 1'b1; iob_valid = 1'b0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0;
      wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0; model_rdata = '0;
      @(negedge clk);
      test_reset();
      test_read_zero_wait();
      test_write_wait();
      test_timeout();
      test_wb_err();
      test_back_to_back();
      test_reset_mid_bus();
      test_cke_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
